// File: rtl/pkt_flit_injector.sv
// Serialises one buffered packet into flits for the router local port, gated by per-vnet credits.
// Optional macro PKT_INJ_BACK2BACK_EN lets a new packet load in the cycle the last flit issues.
module pkt_flit_injector #(
    parameter int FLIT_WIDTH        = 64,
    parameter int MAX_PACKET_LENGHT = 5,
    parameter int N_BITS_VNET_ID    = 2,
    parameter int N_CREDIT          = 4,
    parameter int N_BITS_CREDIT     = 3,
    parameter int FLIT_TYPE_LSB     = 62
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] pkt_i,
    input  logic [N_BITS_VNET_ID-1:0]             vnet_id_i,
    input  logic                                  pkt_valid_i,
    output logic                                  pkt_ready_o,
    output logic [FLIT_WIDTH-1:0]                 flit_o,
    output logic                                  flit_valid_o,
    output logic [N_BITS_VNET_ID-1:0]             flit_vnet_id_o,
    input  logic [2**N_BITS_VNET_ID-1:0]          credit_in_i,
    output logic                                  error_o
);

    localparam int N_VNET = 2**N_BITS_VNET_ID;
    localparam int LEN_W  = $clog2(MAX_PACKET_LENGHT + 1);

    localparam logic [1:0] FT_HEAD      = 2'b00;
    localparam logic [1:0] FT_TAIL      = 2'b10;
    localparam logic [1:0] FT_HEAD_TAIL = 2'b11;

    localparam logic [N_BITS_CREDIT-1:0] CREDIT_RST = N_BITS_CREDIT'(N_CREDIT);
    localparam logic [N_BITS_CREDIT:0]   CREDIT_MAX = (N_BITS_CREDIT + 1)'(N_CREDIT);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t                    state_q;
    logic [FLIT_WIDTH-1:0]     flits_q [MAX_PACKET_LENGHT];
    logic [N_BITS_VNET_ID-1:0] vnet_q;
    logic [LEN_W-1:0]          len_q;
    logic [LEN_W-1:0]          idx_q;
    logic [N_BITS_CREDIT-1:0]  credit_q [N_VNET];
    logic [N_BITS_CREDIT-1:0]  credit_d [N_VNET];
    logic [N_BITS_CREDIT:0]    credit_ext [N_VNET];
    logic                      credit_ovf;
    logic [FLIT_WIDTH-1:0]     flit_q;
    logic                      flit_valid_q;
    logic [N_BITS_VNET_ID-1:0] flit_vnet_q;
    logic                      error_q;

    logic [LEN_W-1:0] len_d;
    logic             no_tail;
    logic             bad_head;
    logic             issue;
    logic             last;
    logic             accept;

    function automatic logic [1:0] ftype(input logic [FLIT_WIDTH-1:0] f);
        return f[FLIT_TYPE_LSB +: 2];
    endfunction

    assign issue = (state_q == S_SEND) && (credit_q[vnet_q] != '0);
    assign last  = issue && (idx_q == len_q - LEN_W'(1));

`ifdef PKT_INJ_BACK2BACK_EN
    assign pkt_ready_o = !rst && ((state_q == S_IDLE) || last);
`else
    assign pkt_ready_o = !rst && (state_q == S_IDLE);
`endif

    assign accept = pkt_valid_i && pkt_ready_o;

    // Length is the first TAIL at or after flit 1; the descending scan leaves the lowest match.
    always_comb begin
        len_d    = LEN_W'(MAX_PACKET_LENGHT);
        no_tail  = 1'b1;
        bad_head = (ftype(pkt_i[FLIT_WIDTH-1:0]) != FT_HEAD) &&
                   (ftype(pkt_i[FLIT_WIDTH-1:0]) != FT_HEAD_TAIL);
        if (ftype(pkt_i[FLIT_WIDTH-1:0]) == FT_HEAD_TAIL) begin
            len_d   = LEN_W'(1);
            no_tail = 1'b0;
        end else begin
            for (int k = MAX_PACKET_LENGHT - 1; k >= 1; k--) begin
                if (ftype(pkt_i[k*FLIT_WIDTH +: FLIT_WIDTH]) == FT_TAIL) begin
                    len_d   = LEN_W'(k + 1);
                    no_tail = 1'b0;
                end
            end
        end
    end

    // Returns and the local send are netted per vnet; anything above N_CREDIT clips and flags.
    always_comb begin
        credit_ovf = 1'b0;
        for (int v = 0; v < N_VNET; v++) begin
            credit_ext[v] = {1'b0, credit_q[v]}
                          + (N_BITS_CREDIT + 1)'(credit_in_i[v])
                          - (N_BITS_CREDIT + 1)'(issue && (vnet_q == N_BITS_VNET_ID'(v)));
            if (credit_ext[v] > CREDIT_MAX) begin
                credit_d[v] = CREDIT_RST;
                credit_ovf  = 1'b1;
            end else begin
                credit_d[v] = credit_ext[v][N_BITS_CREDIT-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < N_VNET; v++) credit_q[v] <= CREDIT_RST;
        end else begin
            for (int v = 0; v < N_VNET; v++) credit_q[v] <= credit_d[v];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < MAX_PACKET_LENGHT; k++) begin
                flits_q[k] <= pkt_i[k*FLIT_WIDTH +: FLIT_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            vnet_q       <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            flit_q       <= '0;
            flit_valid_q <= 1'b0;
            flit_vnet_q  <= '0;
            error_q      <= 1'b0;
        end else begin
            flit_valid_q <= issue;
            if (issue) begin
                flit_q      <= flits_q[idx_q];
                flit_vnet_q <= vnet_q;
                idx_q       <= idx_q + LEN_W'(1);
                if (last) state_q <= S_IDLE;
            end
            // A same-cycle accept overrides the post-issue bookkeeping above.
            if (accept) begin
                vnet_q  <= vnet_id_i;
                len_q   <= len_d;
                idx_q   <= '0;
                state_q <= S_SEND;
            end
            if ((accept && (no_tail || bad_head)) || credit_ovf) error_q <= 1'b1;
        end
    end

    assign flit_o         = flit_q;
    assign flit_valid_o   = flit_valid_q;
    assign flit_vnet_id_o = flit_vnet_q;
    assign error_o        = error_q;

endmodule
